// File: rtl/l2_wr_req_fifo.sv
// l2_wr_req_fifo: store-request FIFO with alignment drop and line-address hazard lookup
module l2_wr_req_fifo #(
  parameter int DEPTH          = 4,
  parameter int LINE_ADDR_BITS = 28,
  parameter int BITS_PER_WORD  = 64,
  parameter int WORD_BITS      = 2,
  parameter int BYTE_BITS      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LINE_ADDR_BITS-1:0] in_line_addr,
  input  logic [BITS_PER_WORD-1:0]  in_word,
  input  logic [WORD_BITS-1:0]      in_w_off,
  input  logic [BYTE_BITS-1:0]      in_b_off,
  input  logic [2:0]                in_hsize,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [LINE_ADDR_BITS-1:0] out_line_addr,
  output logic [BITS_PER_WORD-1:0]  out_word,
  output logic [WORD_BITS-1:0]      out_w_off,
  output logic [BYTE_BITS-1:0]      out_b_off,
  output logic [2:0]                out_hsize,
  input  logic [LINE_ADDR_BITS-1:0] lookup_addr,
  output logic                      lookup_hit,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      err_misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [LINE_ADDR_BITS-1:0] la_q [DEPTH];
  logic [BITS_PER_WORD-1:0]  wd_q [DEPTH];
  logic [WORD_BITS-1:0]      wo_q [DEPTH];
  logic [BYTE_BITS-1:0]      bo_q [DEPTH];
  logic [2:0]                hs_q [DEPTH];
  logic [DEPTH-1:0]          vld_q;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [CW-1:0]             cnt_q;
  logic                      aligned, push, pop;
  assign aligned = (in_hsize == 3'd0) ||
                   (in_hsize == 3'd1 && !in_b_off[0]) ||
                   (in_hsize == 3'd2 && in_b_off[1:0] == 2'd0) ||
                   (in_hsize == 3'd3 && in_b_off == '0);
  assign in_ready      = cnt_q != CW'(DEPTH);
  assign out_valid     = cnt_q != '0;
  assign push          = in_valid && in_ready && aligned;
  assign pop           = out_valid && out_ready;
  assign count         = cnt_q;
  assign out_line_addr = la_q[rd_ptr];
  assign out_word      = wd_q[rd_ptr];
  assign out_w_off     = wo_q[rd_ptr];
  assign out_b_off     = bo_q[rd_ptr];
  assign out_hsize     = hs_q[rd_ptr];
  always_comb begin
    lookup_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      lookup_hit = lookup_hit | (vld_q[i] && la_q[i] == lookup_addr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt_q        <= '0;
      vld_q        <= '0;
      err_misalign <= 1'b0;
    end else begin
      if (pop) begin
        rd_ptr        <= rd_ptr + 1'b1;
        vld_q[rd_ptr] <= 1'b0;
      end
      if (push) begin
        wr_ptr        <= wr_ptr + 1'b1;
        vld_q[wr_ptr] <= 1'b1;
      end
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      if (in_valid && in_ready && !aligned) err_misalign <= 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      la_q[wr_ptr] <= in_line_addr;
      wd_q[wr_ptr] <= in_word;
      wo_q[wr_ptr] <= in_w_off;
      bo_q[wr_ptr] <= in_b_off;
      hs_q[wr_ptr] <= in_hsize;
    end
  end
  assert property (@(posedge clk) disable iff (rst) cnt_q <= CW'(DEPTH));
  assert property (@(posedge clk) disable iff (rst) out_valid && !out_ready |=>
    $stable({out_line_addr, out_word, out_w_off, out_b_off, out_hsize}));
endmodule

// File: tb/tb_l2_wr_req_fifo.sv
// tb_l2_wr_req_fifo: directed self-checking bench for l2_wr_req_fifo
module tb_l2_wr_req_fifo;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready, lookup_hit, err_misalign;
  logic [27:0] in_line_addr, out_line_addr, lookup_addr;
  logic [63:0] in_word, out_word;
  logic [1:0]  in_w_off, out_w_off;
  logic [2:0]  in_b_off, out_b_off, in_hsize, out_hsize;
  logic [2:0]  count;
  int          vectors = 0;
  int          errs = 0;
  l2_wr_req_fifo dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_line_addr(in_line_addr), .in_word(in_word), .in_w_off(in_w_off),
    .in_b_off(in_b_off), .in_hsize(in_hsize), .out_valid(out_valid),
    .out_ready(out_ready), .out_line_addr(out_line_addr), .out_word(out_word),
    .out_w_off(out_w_off), .out_b_off(out_b_off), .out_hsize(out_hsize),
    .lookup_addr(lookup_addr), .lookup_hit(lookup_hit), .count(count),
    .err_misalign(err_misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  function automatic logic [63:0] wfn(input logic [27:0] a);
    return 64'hDEAD_BEEF_0000_0000 | {36'h0, a};
  endfunction
  task automatic req(input logic v, input logic [27:0] a, input logic [2:0] hs, input logic [2:0] bo);
    in_valid     = v;
    in_line_addr = a;
    in_word      = wfn(a);
    in_w_off     = a[1:0];
    in_hsize     = hs;
    in_b_off     = bo;
  endtask
  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    lookup_addr = 28'h99;
    req(1'b1, 28'h99, 3'd3, 3'd0);
    repeat (3) tick();
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_hit", lookup_hit, 0);
    chk("rst_err", err_misalign, 0);
    for (int i = 0; i < 4; i++) begin
      req(1'b1, 28'h10 + 28'(i), 3'd3, 3'd0);
      tick();
    end
    chk("full_count", count, 4);
    chk("full_in_ready", in_ready, 0);
    req(1'b1, 28'h14, 3'd3, 3'd0);
    out_ready = 1'b1;
    #1;
    chk("full_no_bypass", in_ready, 0);
    out_ready = 1'b0;
    tick();
    chk("fifth_rejected", count, 4);
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", out_valid, 1);
      chk("drain_addr", out_line_addr, 28'h10 + 28'(i));
      chk("drain_word", out_word, wfn(28'h10 + 28'(i)));
      chk("drain_w_off", out_w_off, i);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    chk("drain_count", count, 0);
    req(1'b1, 28'h20, 3'd3, 3'd0);
    tick();
    chk("nofall_valid", out_valid, 1);
    req(1'b1, 28'h21, 3'd3, 3'd0);
    tick();
    for (int i = 0; i < 20; i++) begin
      req(1'b1, 28'h22 + 28'(i), 3'd3, 3'd0);
      out_ready = 1'b1;
      #1;
      chk("stream_addr", out_line_addr, 28'h20 + 28'(i));
      tick();
      chk("stream_count", count, 2);
    end
    in_valid = 1'b0;
    chk("stream_tail0", out_line_addr, 28'h34);
    tick();
    chk("stream_tail1", out_line_addr, 28'h35);
    tick();
    out_ready = 1'b0;
    chk("stream_empty", count, 0);
    req(1'b1, 28'h30, 3'd1, 3'd3);
    #1;
    chk("mis_handshake", in_ready, 1);
    tick();
    chk("mis_count", count, 0);
    chk("mis_err", err_misalign, 1);
    req(1'b1, 28'h31, 3'd0, 3'd5);
    tick();
    chk("byte_ok_count", count, 1);
    req(1'b1, 28'h32, 3'd2, 3'd4);
    tick();
    chk("w32_ok_count", count, 2);
    req(1'b1, 28'h33, 3'd2, 3'd2);
    tick();
    chk("w32_mis_count", count, 2);
    req(1'b1, 28'h34, 3'd4, 3'd0);
    tick();
    chk("hs4_mis_count", count, 2);
    req(1'b1, 28'h35, 3'd3, 3'd4);
    tick();
    chk("w64_mis_count", count, 2);
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("mis_head0", out_line_addr, 28'h31);
    chk("mis_head0_boff", out_b_off, 5);
    tick();
    chk("mis_head1", out_line_addr, 28'h32);
    chk("mis_head1_hs", out_hsize, 2);
    tick();
    out_ready = 1'b0;
    chk("mis_err_sticky", err_misalign, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("err_cleared", err_misalign, 0);
    req(1'b1, 28'h41, 3'd3, 3'd0);
    tick();
    req(1'b1, 28'h40, 3'd3, 3'd0);
    tick();
    in_valid = 1'b0;
    lookup_addr = 28'h41;
    #1;
    chk("hit_41", lookup_hit, 1);
    lookup_addr = 28'h40;
    #1;
    chk("hit_40", lookup_hit, 1);
    lookup_addr = 28'h42;
    #1;
    chk("miss_42", lookup_hit, 0);
    lookup_addr = 28'h41;
    out_ready = 1'b1;
    #1;
    chk("hit_while_pop", lookup_hit, 1);
    tick();
    out_ready = 1'b0;
    #1;
    chk("miss_41_popped", lookup_hit, 0);
    lookup_addr = 28'h55;
    req(1'b1, 28'h55, 3'd3, 3'd0);
    #1;
    chk("miss_same_push", lookup_hit, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("hit_55_next", lookup_hit, 1);
    req(1'b1, 28'h66, 3'd3, 3'd0);
    tick();
    req(1'b1, 28'h77, 3'd3, 3'd0);
    tick();
    in_valid = 1'b0;
    chk("pre_drain_count", count, 4);
    out_ready = 1'b1;
    tick();
    chk("mid_drain_count", count, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    lookup_addr = 28'h77;
    #1;
    chk("rst2_count", count, 0);
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_hit", lookup_hit, 0);
    req(1'b1, 28'h88, 3'd3, 3'd0);
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_head", out_line_addr, 28'h88);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_empty", out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
